shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_seq_if.sv | 36 +++
 rtl/shift_seq_tick_div.sv | 29 ++
 rtl/shift_seq.sv | 129 ++++++++++++
 tb/tb_shift_seq.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the shift_reg sequencer.
package shift_seq_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Job request port plus the shift_reg drive bundle of the sequencer.
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV_W = DEF_DIV_W
);
  localparam int unsigned NB_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [NB_W-1:0]  in_nbits;
  logic [DIV_W-1:0] in_div;
  logic             fill_in;
  logic             abort;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_dir;
  logic [WIDTH-1:0] sr_data;
  logic             sr_ser_in;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, in_dir, in_nbits, in_div, fill_in, abort,
    input  in_ready, sr_load, sr_shift, sr_dir, sr_data, sr_ser_in, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_nbits, in_div, fill_in, abort,
    output in_ready, sr_load, sr_shift, sr_dir, sr_data, sr_ser_in, busy, done
  );

endinterface

// File: rtl/shift_seq_tick_div.sv
// Down-counting rate divider: reloads on load, counts down when enabled, holds at zero.
module tick_div
  import shift_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/shift_seq.sv
// Sequences one load then a paced train of shift pulses into a downstream shift_reg.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic     clk,
  input  logic     rst,
  shift_seq_if.slave bus
);

  localparam int unsigned NB_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [NB_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept, tick, div_load, div_en, div_zero;
  logic [DIV_W-1:0] div_val;
  logic [NB_W-1:0]  nbits_clamp;

  assign accept      = (state_q == StIdle) && bus.in_valid;
  assign nbits_clamp = (bus.in_nbits > NB_W'(WIDTH)) ? NB_W'(WIDTH) : bus.in_nbits;
  assign div_en      = (state_q == StLoad) || (state_q == StShift);
  // Pulse decision runs one cycle ahead so the registered sr_shift lands on time.
  assign tick        = div_en && div_zero && (rem_q != '0);
  assign div_val     = accept ? bus.in_div : div_q;

  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .en       (div_en),
    .load_val (div_val),
    .zero     (div_zero)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    dir_d    = dir_q;
    data_d   = '0;
    load_d   = 1'b0;
    shift_d  = 1'b0;
    div_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d  = StLoad;
          rem_d    = nbits_clamp;
          div_d    = bus.in_div;
          dir_d    = bus.in_dir;
          data_d   = bus.in_data;
          load_d   = 1'b1;
          div_load = 1'b1;
        end
      end
      StLoad:  state_d = (rem_q == '0) ? StDone : StShift;
      StShift: if (shift_q && (rem_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (tick) begin
      shift_d  = 1'b1;
      rem_d    = rem_q - 1'b1;
      div_load = 1'b1;
    end

    // Abort wins over completion and any pending pulse.
    if ((state_q != StIdle) && bus.abort) begin
      state_d = StIdle;
      shift_d = 1'b0;
    end

    if (state_d == StIdle) begin
      dir_d = 1'b0;
      rem_d = '0;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      div_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.sr_load   = load_q;
  assign bus.sr_shift  = shift_q;
  assign bus.sr_dir    = dir_q;
  assign bus.sr_data   = data_q;
  assign bus.sr_ser_in = bus.fill_in;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq with a behavioural downstream shift_reg.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned NB_W  = $clog2(WIDTH + 1);

  typedef struct {
    int               kind;  // 0 load, 1 shift, 2 done
    int               cyc;
    logic [WIDTH-1:0] data;
    logic             dir;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               shift_cnt = 0;
  int               done_cnt = 0;
  logic [WIDTH-1:0] q;
  ev_t              exp_q[$];

  shift_seq_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut_if ();

  shift_seq #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dut_if.sr_load) q <= dut_if.sr_data;
    else if (dut_if.sr_shift)
      q <= dut_if.sr_dir ? {dut_if.sr_ser_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], dut_if.sr_ser_in};
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (!rst) begin
      checks++;
      if ((dut_if.sr_load && dut_if.sr_shift) || (dut_if.in_ready === dut_if.busy) ||
          (!dut_if.sr_load && dut_if.sr_data !== '0) || (!dut_if.busy && dut_if.sr_dir !== 1'b0)) begin
        errors++;
        $display("FAIL invariant cyc=%0d load=%b shift=%b ready=%b busy=%b data=%h dir=%b",
                 cyc, dut_if.sr_load, dut_if.sr_shift, dut_if.in_ready, dut_if.busy,
                 dut_if.sr_data, dut_if.sr_dir);
      end
      kind = dut_if.sr_load ? 0 : dut_if.sr_shift ? 1 : dut_if.done ? 2 : -1;
      if (kind >= 0) begin
        if (kind == 1) shift_cnt++;
        if (kind == 2) done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d required no event", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || cyc != e.cyc || dut_if.sr_dir !== e.dir ||
              (kind == 0 && dut_if.sr_data !== e.data)) begin
            errors++;
            $display("FAIL event kind=%0d cyc=%0d data=%h dir=%b required kind=%0d cyc=%0d data=%h dir=%b",
                     kind, cyc, dut_if.sr_data, dut_if.sr_dir, e.kind, e.cyc, e.data, e.dir);
          end
        end
      end
    end
  end

  // stop_after < 0 keeps the whole job; otherwise only that many shifts and no done.
  task automatic push_job(input int a, input logic [WIDTH-1:0] data, input logic dir,
                          input int nbits, input int div, input int stop_after);
    int n = (nbits > int'(WIDTH)) ? int'(WIDTH) : nbits;
    exp_q.push_back('{0, a + 1, data, dir});
    for (int k = 1; k <= n; k++)
      if (stop_after < 0 || k <= stop_after)
        exp_q.push_back('{1, a + 1 + k * (div + 1), WIDTH'(0), dir});
    if (stop_after < 0) exp_q.push_back('{2, a + 2 + n * (div + 1), WIDTH'(0), dir});
  endtask

  // Entered #1 after a rising edge with the block idle; returns #1 into the LOAD cycle.
  task automatic start_job(input logic [WIDTH-1:0] data, input logic dir, input int nbits,
                           input int div, input logic fill, input int stop_after);
    dut_if.in_data  = data;
    dut_if.in_dir   = dir;
    dut_if.in_nbits = NB_W'(nbits);
    dut_if.in_div   = DIV_W'(div);
    dut_if.fill_in  = fill;
    dut_if.in_valid = 1'b1;
    push_job(cyc, data, dir, nbits, div, stop_after);
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut_if.in_ready !== 1'b1 || dut_if.busy !== 1'b0 || dut_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status ready=%b busy=%b done=%b required 1 0 0",
               dut_if.in_ready, dut_if.busy, dut_if.done);
    end
    checks++;
    if (dut_if.sr_load !== 1'b0 || dut_if.sr_shift !== 1'b0 || dut_if.sr_dir !== 1'b0 ||
        dut_if.sr_data !== '0) begin
      errors++;
      $display("FAIL reset_drive load=%b shift=%b dir=%b data=%h required 0 0 0 00",
               dut_if.sr_load, dut_if.sr_shift, dut_if.sr_dir, dut_if.sr_data);
    end
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_right_shift;
    start_job(8'hA5, 1'b1, 8, 0, 1'b0, -1);
    idle_cycles(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL right_pending got=%0d required 0", exp_q.size());
    end
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL right_q got=%h required 00", q);
    end
  endtask

  task automatic test_left_shift;
    start_job(8'h81, 1'b0, 3, 2, 1'b1, -1);
    checks++;
    if (dut_if.sr_ser_in !== 1'b1) begin
      errors++;
      $display("FAIL ser_in_high got=%b required 1", dut_if.sr_ser_in);
    end
    idle_cycles(13);
    checks++;
    if (exp_q.size() != 0 || q !== 8'h0F) begin
      errors++;
      $display("FAIL left_q got=%h pending=%0d required 0f pending 0", q, exp_q.size());
    end
    dut_if.fill_in = 1'b0;
    #1;
    checks++;
    if (dut_if.sr_ser_in !== 1'b0) begin
      errors++;
      $display("FAIL ser_in_low got=%b required 0", dut_if.sr_ser_in);
    end
  endtask

  task automatic test_nbits_bounds;
    int base = shift_cnt;
    start_job(8'h77, 1'b1, 0, 3, 1'b0, -1);
    idle_cycles(4);
    checks++;
    if (shift_cnt != base || exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_bits shifts=%0d pending=%0d required 0 0", shift_cnt - base, exp_q.size());
    end
    base = shift_cnt;
    start_job(8'h3C, 1'b0, 12, 0, 1'b0, -1);
    idle_cycles(12);
    checks++;
    if (shift_cnt - base != 8 || exp_q.size() != 0 || q !== 8'h00) begin
      errors++;
      $display("FAIL clamp_bits shifts=%0d pending=%0d q=%h required 8 0 00",
               shift_cnt - base, exp_q.size(), q);
    end
    start_job(8'h80, 1'b0, 1, 255, 1'b0, -1);
    idle_cycles(260);
    checks++;
    if (exp_q.size() != 0 || q !== 8'h00) begin
      errors++;
      $display("FAIL div_max pending=%0d q=%h required 0 00", exp_q.size(), q);
    end
  endtask

  task automatic test_abort;
    int base = shift_cnt;
    int dbase = done_cnt;
    int i = 0;
    start_job(8'hFF, 1'b1, 8, 0, 1'b0, 2);
    while (shift_cnt < base + 2 && i < 20) begin
      @(negedge clk); #1;
      i++;
    end
    checks++;
    if (shift_cnt < base + 2) begin
      errors++;
      $display("FAIL abort_wait shifts=%0d required 2", shift_cnt - base);
    end
    dut_if.abort = 1'b1;
    @(posedge clk); #1;
    dut_if.abort = 1'b0;
    checks++;
    if (dut_if.busy !== 1'b0 || dut_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle busy=%b ready=%b required 0 1", dut_if.busy, dut_if.in_ready);
    end
    idle_cycles(10);
    checks++;
    if (shift_cnt - base != 2 || done_cnt != dbase || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_shift shifts=%0d dones=%0d pending=%0d required 2 0 0",
               shift_cnt - base, done_cnt - dbase, exp_q.size());
    end
    // Abort seen while the block sits in LOAD.
    start_job(8'h11, 1'b1, 4, 1, 1'b0, 0);
    dut_if.abort = 1'b1;
    @(posedge clk); #1;
    dut_if.abort = 1'b0;
    idle_cycles(8);
    checks++;
    if (done_cnt != dbase || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_load dones=%0d pending=%0d required 0 0", done_cnt - dbase, exp_q.size());
    end
    // Abort while idle must not stop the accept.
    dut_if.abort = 1'b1;
    start_job(8'h5A, 1'b0, 1, 0, 1'b1, -1);
    dut_if.abort = 1'b0;
    idle_cycles(4);
    checks++;
    if (done_cnt != dbase + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_in_idle dones=%0d pending=%0d required 1 0", done_cnt - dbase, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int a1 = cyc;
    int dbase = done_cnt;
    dut_if.in_data  = 8'hC5;
    dut_if.in_dir   = 1'b1;
    dut_if.in_nbits = NB_W'(2);
    dut_if.in_div   = DIV_W'(1);
    dut_if.fill_in  = 1'b0;
    dut_if.in_valid = 1'b1;
    push_job(a1, 8'hC5, 1'b1, 2, 1, -1);
    push_job(a1 + 7, 8'h1E, 1'b0, 1, 0, -1);
    @(posedge clk); #1;
    dut_if.in_data  = 8'h1E;
    dut_if.in_dir   = 1'b0;
    dut_if.in_nbits = NB_W'(1);
    dut_if.in_div   = DIV_W'(0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (dut_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready cyc=%0d got=%b required 1", cyc - a1, dut_if.in_ready);
    end
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
    idle_cycles(5);
    checks++;
    if (done_cnt != dbase + 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_jobs dones=%0d pending=%0d required 2 0", done_cnt - dbase, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_job;
    int base = shift_cnt;
    int dbase = done_cnt;
    int i = 0;
    start_job(8'hC3, 1'b0, 8, 3, 1'b0, 1);
    while (shift_cnt < base + 1 && i < 20) begin
      @(negedge clk); #1;
      i++;
    end
    checks++;
    if (shift_cnt < base + 1) begin
      errors++;
      $display("FAIL rst_wait shifts=%0d required 1", shift_cnt - base);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dut_if.busy !== 1'b0 || dut_if.done !== 1'b0 || dut_if.sr_load !== 1'b0 ||
        dut_if.sr_shift !== 1'b0 || dut_if.sr_dir !== 1'b0 || dut_if.sr_data !== '0 ||
        dut_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid busy=%b done=%b load=%b shift=%b dir=%b data=%h ready=%b required 0 0 0 0 0 00 1",
               dut_if.busy, dut_if.done, dut_if.sr_load, dut_if.sr_shift, dut_if.sr_dir,
               dut_if.sr_data, dut_if.in_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    start_job(8'h3C, 1'b1, 2, 1, 1'b1, -1);
    idle_cycles(7);
    checks++;
    if (done_cnt != dbase + 1 || exp_q.size() != 0 || q !== 8'hCF) begin
      errors++;
      $display("FAIL rst_next dones=%0d pending=%0d q=%h required 1 0 cf",
               done_cnt - dbase, exp_q.size(), q);
    end
  endtask

  initial begin
    rst             = 1'b1;
    dut_if.in_valid = 1'b0;
    dut_if.in_data  = '0;
    dut_if.in_dir   = 1'b0;
    dut_if.in_nbits = '0;
    dut_if.in_div   = '0;
    dut_if.fill_in  = 1'b0;
    dut_if.abort    = 1'b0;
    test_reset();
    test_right_shift();
    test_left_shift();
    test_nbits_bounds();
    test_abort();
    test_back_to_back();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
